// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 frame constants and receiver state encoding
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: received-byte FIFO with wrap-bit pointers; a pop frees room for a same-cycle push
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PS2_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic do_push, do_pop;
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];
    // pointer advance on accepted push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
    // storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 receiver with frame checking, watchdog and byte FIFO
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       ps2_nextdata,
    output logic [7:0] ps2_data,
    output logic       ps2_ready,
    output logic       ps2_overflow,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = PS2_FRAME_BITS - 1;
    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    rx_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [TW-1:0] wd, wd_n;
    logic [SW-1:0] sr, sr_n;
    logic fall, frame_ok, push_req, full, empty, drop;
    assign fall      = clk_prev && !clk_s2;
    assign frame_ok  = sr[SW-1] && (^sr[PS2_DATA_BITS:0]);
    assign push_req  = (state == CHECK) && frame_ok;
    assign frame_err = (state == CHECK) && !frame_ok;
    assign ps2_ready = !empty;
    assign drop      = push_req && full && !ps2_nextdata;
    // synchronizers idle high like the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {clk_s1, clk_s2, clk_prev} <= 3'b111;
            {dat_s1, dat_s2} <= 2'b11;
        end else begin
            {clk_s1, clk_s2, clk_prev} <= {ps2_clk, clk_s1, clk_s2};
            {dat_s1, dat_s2} <= {ps2_dat, dat_s1};
        end
    end
    // receiver state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wd    <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wd    <= wd_n;
            sr    <= sr_n;
        end
    end
    // next state: shift bits in LSB first, abandon frame on watchdog expiry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wd_n    = wd;
        sr_n    = sr;
        case (state)
            IDLE: begin
                cnt_n = '0;
                wd_n  = '0;
                if (fall && !dat_s2) state_n = SHIFT;
            end
            SHIFT: begin
                if (fall) begin
                    sr_n  = {dat_s2, sr[SW-1:1]};
                    cnt_n = cnt + 4'd1;
                    wd_n  = '0;
                    if (cnt == 4'(SW - 1)) state_n = CHECK;
                end else if (wd == TW'(TIMEOUT_CYCLES)) begin
                    state_n = IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // sticky overflow; a drop outranks the clearing pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ps2_overflow <= 1'b0;
        else if (drop) ps2_overflow <= 1'b1;
        else if (ps2_nextdata && !empty) ps2_overflow <= 1'b0;
    end
    ps2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PS2_DATA_BITS)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_req),
        .pop  (ps2_nextdata),
        .din  (sr[PS2_DATA_BITS-1:0]),
        .dout (ps2_data),
        .full (full),
        .empty(empty)
    );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames with a scoreboard checking every popped byte
module tb_ps2_rx_fifo;
    logic clk = 0, rst = 1, ps2_clk = 1, ps2_dat = 1, ps2_nextdata = 0;
    logic [7:0] ps2_data;
    logic ps2_ready, ps2_overflow, frame_err;
    int total = 0, bad = 0, err_pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    ps2_rx_fifo dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .ps2_nextdata(ps2_nextdata), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every accepted pop is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && frame_err) err_pulses++;
        if (!rst && ps2_ready && ps2_nextdata) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h want nothing", ps2_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ps2_data !== mon_exp) begin
                    bad++;
                    $display("FAIL pop_data: got %0h want %0h", ps2_data, mon_exp);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input logic pop_at_fall);
        ps2_dat = b;
        repeat (10) @(posedge clk);
        #1 ps2_clk = 0;
        if (pop_at_fall) begin
            repeat (3) @(posedge clk);
            #1 ps2_nextdata = 1;
            @(posedge clk);
            #1 ps2_nextdata = 0;
            repeat (16) @(posedge clk);
        end else begin
            repeat (20) @(posedge clk);
        end
        #1 ps2_clk = 1;
        repeat (10) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pop_at_check);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit((~^d) ^ bad_par, 1'b0);
        send_bit(1'b1, pop_at_check);
    endtask

    task automatic pop_one();
        int n = 0;
        @(posedge clk);
        #1;
        while (!ps2_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ps2_ready) begin
            total++;
            bad++;
            $display("FAIL pop_wait: got ready=0 want ready=1");
        end else begin
            ps2_nextdata = 1;
            @(posedge clk);
            #1 ps2_nextdata = 0;
        end
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ps2_ready, 0);
        check("rst_ovf", ps2_overflow, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_data", ps2_data, 8'h00);
        rst = 0;
        repeat (5) @(posedge clk);

        // single valid frame
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0);
        #1;
        check("f1c_ready", ps2_ready, 1);
        check("f1c_data", ps2_data, 8'h1C);
        pop_one();
        check("f1c_empty", ps2_ready, 0);

        // parity error
        send_frame(8'h1C, 1'b1, 1'b0);
        #1;
        check("perr_pulses", err_pulses, 1);
        check("perr_ready", ps2_ready, 0);

        // overflow on ninth frame
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b0);
        end
        #1;
        check("ovf_set", ps2_overflow, 1);
        check("ovf_head", ps2_data, 8'h01);
        pop_one();
        check("ovf_clear", ps2_overflow, 0);
        for (int i = 0; i < 7; i++) pop_one();
        check("ovf_drain", ps2_ready, 0);

        // push while full coincident with pop
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
        end
        #1;
        check("full_noovf", ps2_overflow, 0);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 1'b0, 1'b1);
        #1;
        check("pushpop_ovf", ps2_overflow, 0);
        check("pushpop_head", ps2_data, 8'h12);
        for (int i = 0; i < 8; i++) pop_one();
        check("pushpop_drain", ps2_ready, 0);

        // abandoned partial frame then watchdog recovery
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        repeat (5002) @(posedge clk);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b0);
        #1;
        check("wd_ready", ps2_ready, 1);
        check("wd_data", ps2_data, 8'hF0);
        check("wd_noerr", err_pulses, 1);
        pop_one();
        check("wd_empty", ps2_ready, 0);

        // reset mid-frame with a byte held in the FIFO
        send_frame(8'h33, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1;
        #1;
        check("mid_rst_ready", ps2_ready, 0);
        check("mid_rst_data", ps2_data, 8'h00);
        check("mid_rst_ovf", ps2_overflow, 0);
        check("mid_rst_ferr", frame_err, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (5) @(posedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0);
        #1;
        check("rst5a_data", ps2_data, 8'h5A);
        pop_one();
        check("rst5a_empty", ps2_ready, 0);
        check("end_err_pulses", err_pulses, 1);
        check("end_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
- REQ-001: Parameter FIFO_DEPTH, default 8, number of received-byte entries; SHALL be a power of two, minimum 2.
- REQ-002: Parameter TIMEOUT_CYCLES, default 5000, idle clk cycles mid-frame before the frame is abandoned.
- REQ-003: clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-high reset.
- REQ-005: ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk.
- REQ-006: ps2_dat  input  1  raw PS/2 device data, asynchronous to clk.
- REQ-007: ps2_nextdata  input  1  consumer pop request; takes effect only when ps2_ready=1.
- REQ-008: ps2_data  output  8  byte at FIFO head; valid while ps2_ready=1.
- REQ-009: ps2_ready  output  1  FIFO non-empty.
- REQ-010: ps2_overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
- REQ-011: frame_err  output  1  one-cycle pulse: a completed frame failed start, stop or parity check.

Function
- REQ-012: ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer; a third ps2_clk flop SHALL provide the previous value for edge detection.
- REQ-013: A falling edge SHALL be flagged in the cycle where previous synced ps2_clk=1 and current=0; synced ps2_dat SHALL be sampled in that same cycle.
- REQ-014: Receiver states SHALL be IDLE, SHIFT and CHECK; IDLE->SHIFT on a falling edge that samples 0 (start bit); a 1 sampled in IDLE SHALL be ignored.
- REQ-015: SHIFT SHALL capture 10 further bits (8 data LSB first, parity, stop) with a 4-bit counter; after the stop bit, go to CHECK.
- REQ-016: CHECK SHALL last exactly one cycle; frame valid iff stop=1 and XOR of 8 data bits and parity bit = 1 (odd parity); then return to IDLE.
- REQ-017: Valid frame in CHECK with FIFO not full: byte SHALL be written; ps2_ready=1 and ps2_data reflects the head entry in the next cycle.
- REQ-018: Invalid frame: frame_err=1 for the CHECK cycle only; no FIFO write.
- REQ-019: Valid frame while full: no write, existing contents unchanged, ps2_overflow set next cycle.
- REQ-020: Push and pop in the same cycle while full: fullness SHALL be evaluated after the pop, so the push succeeds and occupancy stays FIFO_DEPTH; ps2_overflow not set.
- REQ-021: Pop when ps2_ready=1 and ps2_nextdata=1; head advances next cycle; ps2_nextdata with ps2_ready=0 SHALL have no effect.
- REQ-022: Push and pop in the same cycle when empty: the push SHALL be written, and the pop ignored.
- REQ-023: Pointers SHALL be log2(FIFO_DEPTH)+1 bits with an extra wrap bit; full = indices equal and wrap bits differ; empty = pointers equal; wrap-around SHALL be seamless.
- REQ-024: ps2_overflow SHALL clear on the first successful pop after being set; a new overflow in that same cycle takes priority and keeps it set.
- REQ-025: In SHIFT, a watchdog counter SHALL reset on every falling edge; when it reaches TIMEOUT_CYCLES, the receiver SHALL return to IDLE, discarding partial bits, without a frame_err pulse.

Reset
- REQ-026: rst=1 SHALL immediately force: state IDLE, bit counter 0, watchdog 0, pointers 0, synchronizer flops 1, ps2_ready=0, ps2_overflow=0, frame_err=0, ps2_data=8'h00.
- REQ-027: Reset during a frame SHALL discard it; reception resumes with the next start bit after rst deasserts.

Structure
- REQ-028: Package ps2_pkg SHALL hold the frame constants (PS2_FRAME_BITS=11, PS2_DATA_BITS=8) and the receiver state enum.
- REQ-029: Storage SHALL be a sub-module ps2_fifo (push, pop, din, dout, full, empty; parameter DEPTH); the receiver FSM, synchronizers and watchdog remain in ps2_rx_fifo.

Verification
- REQ-030: Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1, with parity 0) -> ps2_ready=1, ps2_data=8'h1C; after pop, ps2_ready=0.
- REQ-031: Frame 0x1C with parity bit 1 -> single frame_err pulse; ps2_ready stays 0.
- REQ-032: Nine valid frames 0x01..0x09, no pops -> ps2_overflow=1; pops return 0x01..0x08 in order, then ps2_ready=0; overflow clears on the first pop.
- REQ-033: FIFO full, CHECK of frame 0x2A coincident with a pop -> no overflow; 0x2A read back as the last entry.
- REQ-034: Start bit plus 4 data bits, then idle TIMEOUT_CYCLES+2 cycles, then full frame 0xF0 -> exactly one byte, 0xF0; no frame_err.
- REQ-035: rst pulsed after the 6th bit of a frame, then full frame 0x5A -> only 0x5A received; all outputs at reset values during rst.
